ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 162 ++++++++++++++++
 tb/tb_ctrl_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - one-hot T0..T7 control sequencer: fetch, latched-opcode decode, jumps, load/store.
// Optional HALT decode (opcode 0, rd=rs=all ones) is enabled by defining CTRL_SEQ_HALT_EN.
module ctrl_seq #(
  parameter  int RSEL_W = 2,
  localparam int NREG   = 2**RSEL_W,
  localparam int IR_W   = 4 + 2*RSEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic [IR_W-1:0]   ir,
  input  logic              z,
  output logic              read,
  output logic              write,
  output logic              membus,
  output logic              busmem,
  output logic              arload,
  output logic              arinc,
  output logic              pcload,
  output logic              pcinc,
  output logic              pcbus,
  output logic              drload,
  output logic              drlbus,
  output logic              drhbus,
  output logic              trload,
  output logic              trbus,
  output logic              irload,
  output logic              xload,
  output logic              yload,
  output logic              zload,
  output logic              ybus,
  output logic              clr,
  output logic              halt,
  output logic [2:0]        alus,
  output logic [NREG-1:0]   rload,
  output logic [NREG-1:0]   rbus,
  output logic [7:0]        tstate
);

  typedef enum logic [7:0] {
    T0 = 8'h01, T1 = 8'h02, T2 = 8'h04, T3 = 8'h08,
    T4 = 8'h10, T5 = 8'h20, T6 = 8'h40, T7 = 8'h80
  } tstate_e;

  localparam logic [NREG-1:0] ONE = NREG'(1);

  tstate_e           t_q, t_d;
  logic [3:0]        op_q;
  logic [RSEL_W-1:0] rd_q, rs_q;
  logic              taken_q, post_rst_q, halt_q;
  logic              run, active, jt_now, take, halt_set;
  logic [NREG-1:0]   rd_oh, rs_oh;

  assign run    = (cpustate == 2'b11);
  // The cycle right after reset and a halted CPU both idle at T0 with every control low.
  assign active = run && !post_rst_q && !halt_q;
  assign rd_oh  = ONE << rd_q;
  assign rs_oh  = ONE << rs_q;
  assign jt_now = (op_q == 4'hB) || (op_q == 4'hC && z) || (op_q == 4'hD && !z);
  assign take   = (t_q == T3) ? jt_now : taken_q;

`ifdef CTRL_SEQ_HALT_EN
  assign halt_set = active && (t_q == T3) && (op_q == 4'h0) && (&{rd_q, rs_q});
`else
  assign halt_set = 1'b0;
`endif

  assign halt   = halt_q;
  assign tstate = t_q;

  always_comb begin
    read = 1'b0; write = 1'b0; membus = 1'b0; busmem = 1'b0;
    arload = 1'b0; arinc = 1'b0; pcload = 1'b0; pcinc = 1'b0; pcbus = 1'b0;
    drload = 1'b0; drlbus = 1'b0; drhbus = 1'b0; trload = 1'b0; trbus = 1'b0;
    irload = 1'b0; xload = 1'b0; yload = 1'b0; zload = 1'b0; ybus = 1'b0; clr = 1'b0;
    alus = 3'b000; rload = '0; rbus = '0;
    if (active) begin
      case (t_q)
        T0: begin pcbus = 1'b1; arload = 1'b1; end
        T1: begin read = 1'b1; membus = 1'b1; irload = 1'b1; pcinc = 1'b1; end
        T2: begin pcbus = 1'b1; arload = 1'b1; end
        default: begin
          case (op_q)
            4'h0: clr = (t_q == T3);
            4'h1, 4'h3, 4'h5, 4'h6: begin
              if (t_q == T3) begin rbus = rs_oh; xload = 1'b1; end
              if (t_q == T4) begin rbus = rd_oh; yload = 1'b1; zload = 1'b1; alus = 3'(op_q - 4'd1); end
              if (t_q == T5) begin ybus = 1'b1; rload = rd_oh; clr = 1'b1; end
            end
            4'h2, 4'h4, 4'h7, 4'h8: begin
              if (t_q == T3) begin rbus = rd_oh; yload = 1'b1; zload = 1'b1; alus = 3'(op_q - 4'd1); end
              if (t_q == T4) begin ybus = 1'b1; rload = rd_oh; clr = 1'b1; end
            end
            4'h9: if (t_q == T3) begin rbus = rs_oh; rload = rd_oh; clr = 1'b1; end
            4'hA: begin
              if (t_q == T3) begin read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; end
              if (t_q == T4) begin drlbus = 1'b1; rload = rd_oh; clr = 1'b1; end
            end
            4'hB, 4'hC, 4'hD: begin
              if (take) begin
                if (t_q == T3) begin read = 1'b1; membus = 1'b1; drload = 1'b1; arinc = 1'b1; end
                if (t_q == T4) begin read = 1'b1; membus = 1'b1; drload = 1'b1; trload = 1'b1; end
                if (t_q == T5) begin drhbus = 1'b1; trbus = 1'b1; pcload = 1'b1; clr = 1'b1; end
              end else begin
                pcinc = (t_q == T3) || (t_q == T4);
                clr   = (t_q == T4);
              end
            end
            default: begin
              if (t_q == T3) begin read = 1'b1; membus = 1'b1; drload = 1'b1; arinc = 1'b1; pcinc = 1'b1; end
              if (t_q == T4) begin read = 1'b1; membus = 1'b1; drload = 1'b1; trload = 1'b1; pcinc = 1'b1; end
              if (t_q == T5) begin drhbus = 1'b1; trbus = 1'b1; arload = 1'b1; end
              if (t_q == T6) begin
                drload = 1'b1;
                if (op_q == 4'hE) begin read = 1'b1; membus = 1'b1; end
                else rbus = rs_oh;
              end
              if (t_q == T7) begin
                drlbus = 1'b1; clr = 1'b1;
                if (op_q == 4'hE) rload = rd_oh;
                else begin busmem = 1'b1; write = 1'b1; end
              end
            end
          endcase
        end
      endcase
    end
    if (!active || clr) t_d = T0;
    else                t_d = tstate_e'({t_q[6:0], t_q[7]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q        <= T0;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      taken_q    <= 1'b0;
      halt_q     <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      post_rst_q <= 1'b0;
      t_q        <= t_d;
      if (!run) begin
        op_q    <= '0;
        rd_q    <= '0;
        rs_q    <= '0;
        taken_q <= 1'b0;
        halt_q  <= 1'b0;
      end else begin
        if (active && t_q == T2) begin
          op_q <= ir[IR_W-1:IR_W-4];
          rd_q <= ir[2*RSEL_W-1:RSEL_W];
          rs_q <= ir[RSEL_W-1:0];
        end
        if (active && t_q == T3) taken_q <= jt_now;
        if (halt_set) halt_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - sequence-queue model of ctrl_seq compared every cycle, plus literal pins.
module tb_ctrl_seq;
  localparam int RSEL_W = 2;

  logic clk = 1'b0;
  logic rst, z;
  logic [1:0] cpustate;
  logic [7:0] ir;
  logic read, write, membus, busmem, arload, arinc, pcload, pcinc, pcbus;
  logic drload, drlbus, drhbus, trload, trbus, irload, xload, yload, zload, ybus, clr, halt;
  logic [2:0] alus;
  logic [3:0] rload, rbus;
  logic [7:0] tstate;

  ctrl_seq #(.RSEL_W(RSEL_W)) dut (
    .clk(clk), .rst(rst), .cpustate(cpustate), .ir(ir), .z(z),
    .read(read), .write(write), .membus(membus), .busmem(busmem),
    .arload(arload), .arinc(arinc), .pcload(pcload), .pcinc(pcinc), .pcbus(pcbus),
    .drload(drload), .drlbus(drlbus), .drhbus(drhbus), .trload(trload), .trbus(trbus),
    .irload(irload), .xload(xload), .yload(yload), .zload(zload), .ybus(ybus),
    .clr(clr), .halt(halt), .alus(alus), .rload(rload), .rbus(rbus), .tstate(tstate)
  );

  always #5 clk = ~clk;

  localparam logic [20:0] F_READ   = 21'd1 << 20, F_WRITE  = 21'd1 << 19, F_MEMBUS = 21'd1 << 18;
  localparam logic [20:0] F_BUSMEM = 21'd1 << 17, F_ARLOAD = 21'd1 << 16, F_ARINC  = 21'd1 << 15;
  localparam logic [20:0] F_PCLOAD = 21'd1 << 14, F_PCINC  = 21'd1 << 13, F_PCBUS  = 21'd1 << 12;
  localparam logic [20:0] F_DRLOAD = 21'd1 << 11, F_DRLBUS = 21'd1 << 10, F_DRHBUS = 21'd1 << 9;
  localparam logic [20:0] F_TRLOAD = 21'd1 << 8,  F_TRBUS  = 21'd1 << 7,  F_IRLOAD = 21'd1 << 6;
  localparam logic [20:0] F_XLOAD  = 21'd1 << 5,  F_YLOAD  = 21'd1 << 4,  F_ZLOAD  = 21'd1 << 3;
  localparam logic [20:0] F_YBUS   = 21'd1 << 2,  F_CLR    = 21'd1 << 1,  F_HALT   = 21'd1;
`ifdef CTRL_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // Observed word: {21 flags, alus, rload, rbus, tstate}
  logic [39:0] obs;
  assign obs = {read, write, membus, busmem, arload, arinc, pcload, pcinc, pcbus,
                drload, drlbus, drhbus, trload, trbus, irload, xload, yload, zload,
                ybus, clr, halt, alus, rload, rbus, tstate};

  logic [39:0] exp_q[$];
  logic [39:0] hist[$];
  logic [39:0] cmp_w;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name, input logic [39:0] got, input logic [39:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit fl(input logic [39:0] w, input logic [20:0] f);
    return (w[39:19] & f) != 21'd0;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_w = exp_q.pop_front();
      hist.push_back(obs);
      check(obs === cmp_w, "seq", obs, cmp_w);
    end
  end

  task automatic push_w(input logic [20:0] f, input logic [2:0] a, input logic [3:0] rl,
                        input logic [3:0] rb, input int t);
    exp_q.push_back({f, a, rl, rb, 8'(1 << t)});
  endtask

  // Expected per-cycle control words of one instruction, straight from the opcode tables.
  task automatic model_instr(input logic [7:0] i, input logic zz);
    logic [3:0] op, rd1h, rs1h;
    logic [2:0] alu;
    bit tk;
    op   = i[7:4];
    rd1h = 4'(1 << i[3:2]);
    rs1h = 4'(1 << i[1:0]);
    alu  = 3'(op - 4'd1);
    tk   = (op == 4'hB) || (op == 4'hC && zz) || (op == 4'hD && !zz);
    push_w(F_PCBUS | F_ARLOAD, 3'd0, 4'd0, 4'd0, 0);
    push_w(F_READ | F_MEMBUS | F_IRLOAD | F_PCINC, 3'd0, 4'd0, 4'd0, 1);
    push_w(F_PCBUS | F_ARLOAD, 3'd0, 4'd0, 4'd0, 2);
    case (op)
      4'h0: push_w(F_CLR, 3'd0, 4'd0, 4'd0, 3);
      4'h1, 4'h3, 4'h5, 4'h6: begin
        push_w(F_XLOAD, 3'd0, 4'd0, rs1h, 3);
        push_w(F_YLOAD | F_ZLOAD, alu, 4'd0, rd1h, 4);
        push_w(F_YBUS | F_CLR, 3'd0, rd1h, 4'd0, 5);
      end
      4'h2, 4'h4, 4'h7, 4'h8: begin
        push_w(F_YLOAD | F_ZLOAD, alu, 4'd0, rd1h, 3);
        push_w(F_YBUS | F_CLR, 3'd0, rd1h, 4'd0, 4);
      end
      4'h9: push_w(F_CLR, 3'd0, rd1h, rs1h, 3);
      4'hA: begin
        push_w(F_READ | F_MEMBUS | F_DRLOAD | F_PCINC, 3'd0, 4'd0, 4'd0, 3);
        push_w(F_DRLBUS | F_CLR, 3'd0, rd1h, 4'd0, 4);
      end
      4'hB, 4'hC, 4'hD: begin
        if (tk) begin
          push_w(F_READ | F_MEMBUS | F_DRLOAD | F_ARINC, 3'd0, 4'd0, 4'd0, 3);
          push_w(F_READ | F_MEMBUS | F_DRLOAD | F_TRLOAD, 3'd0, 4'd0, 4'd0, 4);
          push_w(F_DRHBUS | F_TRBUS | F_PCLOAD | F_CLR, 3'd0, 4'd0, 4'd0, 5);
        end else begin
          push_w(F_PCINC, 3'd0, 4'd0, 4'd0, 3);
          push_w(F_PCINC | F_CLR, 3'd0, 4'd0, 4'd0, 4);
        end
      end
      default: begin
        push_w(F_READ | F_MEMBUS | F_DRLOAD | F_ARINC | F_PCINC, 3'd0, 4'd0, 4'd0, 3);
        push_w(F_READ | F_MEMBUS | F_DRLOAD | F_TRLOAD | F_PCINC, 3'd0, 4'd0, 4'd0, 4);
        push_w(F_DRHBUS | F_TRBUS | F_ARLOAD, 3'd0, 4'd0, 4'd0, 5);
        if (op == 4'hE) begin
          push_w(F_READ | F_MEMBUS | F_DRLOAD, 3'd0, 4'd0, 4'd0, 6);
          push_w(F_DRLBUS | F_CLR, 3'd0, rd1h, 4'd0, 7);
        end else begin
          push_w(F_DRLOAD, 3'd0, 4'd0, rs1h, 6);
          push_w(F_DRLBUS | F_BUSMEM | F_WRITE | F_CLR, 3'd0, 4'd0, 4'd0, 7);
        end
      end
    endcase
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check(exp_q.size() == 0, "drain_timeout", 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  task automatic run_instr(input logic [7:0] i, input logic zz);
    ir = i;
    z  = zz;
    hist.delete();
    model_instr(i, zz);
    drain();
  endtask

  logic [8:0] vecs[18] = '{
    9'h016, 9'h02D, 9'h03B, 9'h047, 9'h055, 9'h069, 9'h07A, 9'h08C, 9'h09E,
    9'h0A8, 9'h0B0, 9'h1C0, 9'h0C0, 9'h0D0, 9'h1D0, 9'h0E4, 9'h0F3, 9'h000
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_pc, cnt_wr;
    bit  any_pl;
    rst = 1'b1; cpustate = 2'b11; ir = 8'h00; z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(obs == 40'h01, "reset_state", obs, 40'h01);
    rst = 1'b0;
    push_w(21'd0, 3'd0, 4'd0, 4'd0, 0);
    drain();

    foreach (vecs[n]) run_instr(vecs[n][7:0], vecs[n][8]);

    // ADD r1,r2
    run_instr(8'h16, 1'b0);
    if (hist.size() == 6) begin
      check(hist[3][11:8] == 4'b0100 && fl(hist[3], F_XLOAD), "add_t3", hist[3], 40'h0);
      check(hist[4][11:8] == 4'b0010 && fl(hist[4], F_ZLOAD) && hist[4][18:16] == 3'b000, "add_t4", hist[4], 40'h0);
      check(hist[5][15:12] == 4'b0010 && fl(hist[5], F_CLR), "add_t5", hist[5], 40'h0);
    end
    check(tstate == 8'h01, "add_next_t0", 40'(tstate), 40'h01);

    // JMPZ taken / not taken
    run_instr(8'hC0, 1'b1);
    check(hist.size() == 6 && fl(hist[5], F_PCLOAD) && fl(hist[5], F_CLR), "jmpz_taken", 40'(hist.size()), 40'd6);
    run_instr(8'hC0, 1'b0);
    any_pl = 1'b0;
    foreach (hist[n]) if (fl(hist[n], F_PCLOAD)) any_pl = 1'b1;
    check(hist.size() == 5 && fl(hist[3], F_PCINC) && fl(hist[4], F_PCINC) && fl(hist[4], F_CLR) && !any_pl,
          "jmpz_not_taken", 40'(hist.size()), 40'd5);

    // STORE r0 <- r3
    run_instr(8'hF3, 1'b0);
    cnt_pc = 0; cnt_wr = 0;
    foreach (hist[n]) begin
      if (fl(hist[n], F_PCINC)) cnt_pc++;
      if (fl(hist[n], F_WRITE) || fl(hist[n], F_BUSMEM)) cnt_wr++;
    end
    check(cnt_pc == 3, "store_pcinc_count", 40'(cnt_pc), 40'd3);
    check(hist.size() == 8 && cnt_wr == 1 && fl(hist[7], F_WRITE) && fl(hist[7], F_BUSMEM) && hist[6][11:8] == 4'b1000,
          "store_t6_t7", 40'(cnt_wr), 40'd1);

    // Reset in T5 of LOAD
    ir = 8'hE4; z = 1'b0; hist.delete();
    model_instr(8'hE4, 1'b0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check(obs == 40'h01, "reset_mid_load", obs, 40'h01);
    push_w(21'd0, 3'd0, 4'd0, 4'd0, 0);
    drain();
    run_instr(8'h9E, 1'b0);

    // Leave RUN at T4 of LOAD, come back after two idle cycles
    ir = 8'hE4; z = 1'b0; hist.delete();
    model_instr(8'hE4, 1'b0);
    repeat (4) void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    cpustate = 2'b01;
    push_w(21'd0, 3'd0, 4'd0, 4'd0, 4);
    push_w(21'd0, 3'd0, 4'd0, 4'd0, 0);
    push_w(21'd0, 3'd0, 4'd0, 4'd0, 0);
    drain();
    check(obs == 40'h01, "abort_idle", obs, 40'h01);
    cpustate = 2'b11;
    run_instr(8'hE4, 1'b0);

    // Opcode 0 with rd=rs=all ones
    if (HALT_EN) begin
      run_instr(8'h0F, 1'b0);
      for (int n = 0; n < 10; n++) push_w(F_HALT, 3'd0, 4'd0, 4'd0, 0);
      drain();
      check(halt == 1'b1 && tstate == 8'h01, "halt_hold", obs, {F_HALT, 19'h01});
      push_w(F_HALT, 3'd0, 4'd0, 4'd0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check(halt == 1'b0, "halt_cleared", 40'(halt), 40'd0);
      push_w(21'd0, 3'd0, 4'd0, 4'd0, 0);
      drain();
    end else begin
      run_instr(8'h0F, 1'b0);
      check(halt == 1'b0 && tstate == 8'h01, "nop_0f_no_halt", obs, 40'h01);
    end
    run_instr(8'h16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
